ssd_capture: RTL

Receive-side monitor for the 4-digit common-anode 7-segment scan bus. It samples the multiplexed `an`/`seg` lines driven by the display scanner and re-synchronises them into its own clock. It decodes each digit pattern back to BCD and reports one complete 4-digit frame at a time. The block sits beside the stopwatch display path and exposes the displayed value as digits for on-board checking and logging.

---
 rtl/ssd_capture.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ssd_capture.sv
// rtl/ssd_capture.sv - 7-segment scan bus monitor that rebuilds 4-digit BCD frames
module ssd_capture #(
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       sel_err,
  output logic       stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ACC  = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {WAIT, ACCEPT, HOLD} state_t;

  state_t        state;
  state_t        state_nx;
  logic [10:0]   sync1;
  logic [10:0]   sync2;
  logic [10:0]   p;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          same;
  logic [3:0]    sel_n;
  logic          sel_one;
  logic          sel_many;
  logic [1:0]    idx;
  logic [3:0]    dec_val;
  logic          dec_bad;
  logic          take_digit;
  logic          take_fault;
  logic [3:0]    slot [4];
  logic [3:0]    mask;
  logic          err_acc;
  logic [IW-1:0] idle;

  // Bring the asynchronous {an, seg} word into clk and keep the previous synchronized word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      p     <= '0;
    end else begin
      sync1 <= {an, seg};
      sync2 <= sync1;
      p     <= sync2;
    end
  end

  assign same = (sync2 == p);

  // Count consecutive unchanged samples, saturating so a long dwell cannot wrap
  always_comb begin
    cnt_nx = '0;
    if (same) begin
      cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
  end

  // Stability counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nx;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT;
    else     state <= state_nx;
  end

  // Accept a word once per stable period; a change seen during ACCEPT re-arms immediately
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT:    if (same && cnt_nx == CNT_ACC) state_nx = ACCEPT;
      ACCEPT:  state_nx = same ? HOLD : WAIT;
      HOLD:    if (!same) state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  // Classify the accepted anode word (p holds the word that was stable)
  assign sel_n      = ~p[10:7];
  assign sel_one    = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
  assign sel_many   = (sel_n != 4'd0) && !sel_one;
  assign take_digit = (state == ACCEPT) && sel_one;
  assign take_fault = (state == ACCEPT) && sel_many;

  // Index of the single selected digit
  always_comb begin
    idx = 2'd0;
    case (sel_n)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Active-low segment pattern back to BCD; anything else is undecodable
  always_comb begin
    dec_val = 4'hF;
    dec_bad = 1'b1;
    case (p[6:0])
      7'h40: begin dec_val = 4'd0; dec_bad = 1'b0; end
      7'h79: begin dec_val = 4'd1; dec_bad = 1'b0; end
      7'h24: begin dec_val = 4'd2; dec_bad = 1'b0; end
      7'h30: begin dec_val = 4'd3; dec_bad = 1'b0; end
      7'h19: begin dec_val = 4'd4; dec_bad = 1'b0; end
      7'h12: begin dec_val = 4'd5; dec_bad = 1'b0; end
      7'h02: begin dec_val = 4'd6; dec_bad = 1'b0; end
      7'h78: begin dec_val = 4'd7; dec_bad = 1'b0; end
      7'h00: begin dec_val = 4'd8; dec_bad = 1'b0; end
      7'h10: begin dec_val = 4'd9; dec_bad = 1'b0; end
      default: ;
    endcase
  end

  // Frame assembly: slot capture, completion, idle timeout and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0]     <= 4'd0;
      slot[1]     <= 4'd0;
      slot[2]     <= 4'd0;
      slot[3]     <= 4'd0;
      mask        <= 4'd0;
      err_acc     <= 1'b0;
      idle        <= '0;
      d0          <= 4'd0;
      d1          <= 4'd0;
      d2          <= 4'd0;
      d3          <= 4'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sel_err     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sel_err     <= take_fault;
      if (take_digit) slot[idx] <= dec_val;
      if (mask == 4'hF) begin
        // Completion beats a coincident timeout; a digit taken now starts the next frame
        d0          <= slot[0];
        d1          <= slot[1];
        d2          <= slot[2];
        d3          <= slot[3];
        frame_err   <= err_acc;
        frame_valid <= 1'b1;
        stale       <= 1'b0;
        mask        <= take_digit ? sel_n : 4'd0;
        err_acc     <= take_digit & dec_bad;
        idle        <= '0;
      end else if (idle == IDLE_MAX) begin
        // Drop the partial frame but keep the last published one
        stale       <= 1'b1;
        mask        <= take_digit ? sel_n : 4'd0;
        err_acc     <= take_digit & dec_bad;
        idle        <= '0;
      end else if (take_digit) begin
        mask        <= mask | sel_n;
        err_acc     <= err_acc | dec_bad;
        idle        <= '0;
      end else begin
        idle        <= idle + IW'(1);
      end
    end
  end

endmodule
